frame_strobe_ctrl: RTL and testbench
====================================

FRAME_STROBE_CTRL -- requirements
Module: frame_strobe_ctrl

Interface
REQ-001 Parameter MaxFramesPerCol, default 20, number of frame strobes per column.
REQ-002 Parameter FrameBitsPerRow, default 32, width of one frame data word.
REQ-003 Parameter NumColumns, default 8, number of fabric columns addressed.
REQ-004 Parameter StrobeLen, default 2, cycles FrameStrobe stays high per write; legal range 1..15.
REQ-005 Port CLK  in  1  configuration clock; all state changes on its rising edge.
REQ-006 Port reset  in  1  reset; synchronous and active-high.
REQ-007 Port cfg_valid  in  1  command present.
REQ-008 Port cfg_ready  out  1  controller able to accept a command.
REQ-009 Port cfg_col  in  5  target column index.
REQ-010 Port cfg_frame  in  5  target frame index within the column.
REQ-011 Port cfg_data  in  FrameBitsPerRow  frame data word.
REQ-012 Port FrameData  out  FrameBitsPerRow  registered frame data driven to the column rows.
REQ-013 Port FrameStrobe  out  MaxFramesPerCol  one-hot frame write strobe, fed into the column FrameStrobe chain.
REQ-014 Port ColSelect  out  NumColumns  one-hot column enable, qualifies FrameStrobe.
REQ-015 Port done  out  1  single-cycle pulse when a command completes.
REQ-016 Port err  out  1  sticky out-of-range flag.
REQ-017 Port err_clr  in  1  clears err.
REQ-018 Port frame_count  out  16  saturating count of frames successfully strobed.

Function
REQ-019 Handshake: command accepted on a CLK edge where cfg_valid and cfg_ready are both 1; cfg_col/cfg_frame/cfg_data captured only then.
REQ-020 cfg_ready is 1 only in IDLE; cfg_valid held while cfg_ready=0 causes no side effects.
REQ-021 States: IDLE, SETUP, STROBE, HOLD.
REQ-022 IDLE -> SETUP on an accepted in-range command (cfg_col < NumColumns, cfg_frame < MaxFramesPerCol).
REQ-023 SETUP lasts exactly 1 cycle: FrameData = captured data, ColSelect = one-hot(col), FrameStrobe = 0.
REQ-024 STROBE lasts exactly StrobeLen cycles, tracked by a 4-bit down-counter: FrameStrobe = one-hot(frame), FrameData and ColSelect held.
REQ-025 HOLD lasts exactly 1 cycle: FrameStrobe = 0, FrameData and ColSelect held; done = 1; frame_count increments unless already 0xFFFF.
REQ-026 HOLD -> IDLE; in IDLE, FrameStrobe = 0 and ColSelect = 0; FrameData retains its last value.
REQ-027 Latency: accept at edge T; FrameStrobe high in cycles T+2 .. T+1+StrobeLen; done in cycle T+2+StrobeLen; cfg_ready = 1 again in cycle T+3+StrobeLen.
REQ-028 Out-of-range accepted command: state stays IDLE, err set on the next edge, no strobe, no ColSelect, no done pulse, frame_count unchanged.
REQ-029 err_clr and an out-of-range accept on the same edge: err = 1 (set wins).
REQ-030 FrameStrobe and ColSelect are never non-zero in the same cycle as a different captured address; at most one bit of each is ever high.

Reset
REQ-031 While reset = 1 at an edge: state = IDLE, FrameStrobe = 0, ColSelect = 0, FrameData = 0, done = 0, err = 0, frame_count = 0, counter = 0.
REQ-032 Reset asserted mid-SETUP/STROBE/HOLD aborts the write on that edge: strobe drops next cycle, no done pulse, no frame_count increment.
REQ-033 cfg_ready = 0 during any cycle in which reset = 1.

Structure
REQ-034 Shared package frame_cfg_pkg holds the state enumeration, default parameter values and the 5-bit address width constant.
REQ-035 One sub-module onehot_dec (parameterised index width and output width; out-of-range index yields all-zero) used twice, for FrameStrobe and ColSelect.
REQ-036 All outputs are driven from flops; no combinational path from cfg_* inputs to any output except cfg_ready (which depends on state only).

Verification
REQ-037 Defaults, accept col=3 frame=7 data=0xDEADBEEF at T -> ColSelect=0x08 from T+1, FrameStrobe=0x00080 in T+2..T+3, done at T+4, frame_count=1, cfg_ready at T+5.
REQ-038 Two back-to-back commands (col=0 frame=0, col=7 frame=19) with cfg_valid held high -> second accepted exactly 5 cycles after first; FrameStrobe values 0x00001 then 0x80000; frame_count=2.
REQ-039 Command col=8 frame=2 -> err=1 next cycle, FrameStrobe/ColSelect stay 0, no done; err_clr -> err=0; err_clr plus new col=9 accept on same edge -> err=1.
REQ-040 Reset asserted in first STROBE cycle -> FrameStrobe=0 next cycle, done never pulses, frame_count unchanged, cfg_ready=1 the cycle after reset releases.
REQ-041 StrobeLen=1 and StrobeLen=15 builds, col=1 frame=5 -> FrameStrobe high for exactly 1 and 15 cycles respectively, bit 5 only.
REQ-042 Preload frame_count to 0xFFFE via 0xFFFE writes (or force), issue three writes -> frame_count saturates at 0xFFFF.

Source files
------------

// File: rtl/frame_cfg_pkg.sv
// Shared constants for the frame strobe controller:
// FSM state encodings, default geometry and address width.
package frame_cfg_pkg;

   localparam int AddrW = 5;

   localparam int DefMaxFrames = 20;
   localparam int DefFrameBits = 32;
   localparam int DefNumCols   = 8;
   localparam int DefStrobeLen = 2;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_STROBE = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

endpackage

// File: rtl/frame_strobe_ctrl_if.sv
// Command handshake bundle between a configuration
// master and the frame strobe controller.
interface frame_strobe_ctrl_if
   import frame_cfg_pkg::*;
#(
   parameter int FrameBits = DefFrameBits
);

   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [AddrW-1:0]     cfg_col;
   logic [AddrW-1:0]     cfg_frame;
   logic [FrameBits-1:0] cfg_data;

   modport master (
      output cfg_valid,
      output cfg_col,
      output cfg_frame,
      output cfg_data,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_col,
      input  cfg_frame,
      input  cfg_data,
      output cfg_ready
   );

endinterface

// File: rtl/frame_strobe_ctrl_onehot_dec.sv
// Index to one-hot decoder; an index past the
// output width decodes to all zeros.
module onehot_dec #(
   parameter int IdxW = 5,
   parameter int OutW = 8
) (
   input  logic [IdxW-1:0] idx,
   output logic [OutW-1:0] oh
);

   always_comb begin
      oh = '0;
      for (int i = 0; i < OutW; i++) begin
         if (int'(idx) == i) oh[i] = 1'b1;
      end
   end

endmodule

// File: rtl/frame_strobe_ctrl.sv
// Frame write sequencer: accepts one command, then
// drives ColSelect, a timed FrameStrobe and a done pulse.
module frame_strobe_ctrl
   import frame_cfg_pkg::*;
#(
   parameter int MaxFramesPerCol = DefMaxFrames,
   parameter int FrameBitsPerRow = DefFrameBits,
   parameter int NumColumns      = DefNumCols,
   parameter int StrobeLen       = DefStrobeLen
) (
   input  logic                       CLK,
   input  logic                       reset,
   frame_strobe_ctrl_if.slave         cfg,
   input  logic                       err_clr,
   output logic [FrameBitsPerRow-1:0] FrameData,
   output logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic [NumColumns-1:0]      ColSelect,
   output logic                       done,
   output logic                       err,
   output logic [15:0]                frame_count
);

   localparam logic [3:0] CntInit = 4'(StrobeLen - 1);

   logic [1:0]                 state;
   logic [3:0]                 cnt;
   logic [AddrW-1:0]           frame_q;
   logic                       accept;
   logic                       in_range;
   logic [NumColumns-1:0]      col_oh;
   logic [MaxFramesPerCol-1:0] frm_oh;

   assign cfg.cfg_ready = (state == S_IDLE) && !reset;
   assign accept = cfg.cfg_valid && cfg.cfg_ready;
   assign in_range = (int'(cfg.cfg_col) < NumColumns) &&
                     (int'(cfg.cfg_frame) < MaxFramesPerCol);

   onehot_dec #(.IdxW(AddrW), .OutW(NumColumns)) u_col_dec (
      .idx (cfg.cfg_col),
      .oh  (col_oh)
   );

   onehot_dec #(.IdxW(AddrW), .OutW(MaxFramesPerCol)) u_frm_dec (
      .idx (frame_q),
      .oh  (frm_oh)
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         frame_q     <= '0;
         FrameData   <= '0;
         FrameStrobe <= '0;
         ColSelect   <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         frame_count <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept && in_range) begin
                  state     <= S_SETUP;
                  frame_q   <= cfg.cfg_frame;
                  FrameData <= cfg.cfg_data;
                  ColSelect <= col_oh;
               end
            end
            S_SETUP: begin
               state       <= S_STROBE;
               cnt         <= CntInit;
               FrameStrobe <= frm_oh;
            end
            S_STROBE: begin
               if (cnt == 4'd0) begin
                  state       <= S_HOLD;
                  FrameStrobe <= '0;
                  done        <= 1'b1;
                  if (frame_count != 16'hFFFF)
                     frame_count <= frame_count + 16'd1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_HOLD: begin
               state     <= S_IDLE;
               ColSelect <= '0;
            end
            default: state <= S_IDLE;
         endcase
         // a rejected command outranks a same-edge clear
         if (accept && !in_range) err <= 1'b1;
         else if (err_clr)        err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_frame_strobe_ctrl.sv
// Directed self-checking bench for frame_strobe_ctrl,
// including StrobeLen=1 and StrobeLen=15 builds.
module tb_frame_strobe_ctrl;

   logic CLK;
   logic reset;
   logic err_clr;

   int pass_cnt;
   int total_cnt;

   frame_strobe_ctrl_if #(.FrameBits(32)) cif ();
   frame_strobe_ctrl_if #(.FrameBits(32)) cif1 ();
   frame_strobe_ctrl_if #(.FrameBits(32)) cif15 ();

   logic [31:0] fd, fd1, fd15;
   logic [19:0] fs, fs1, fs15;
   logic [7:0]  cs, cs1, cs15;
   logic        dn, dn1, dn15;
   logic        er, er1, er15;
   logic [15:0] fc, fc1, fc15;

   frame_strobe_ctrl dut (
      .CLK(CLK), .reset(reset), .cfg(cif.slave), .err_clr(err_clr),
      .FrameData(fd), .FrameStrobe(fs), .ColSelect(cs),
      .done(dn), .err(er), .frame_count(fc)
   );

   frame_strobe_ctrl #(.StrobeLen(1)) dut1 (
      .CLK(CLK), .reset(reset), .cfg(cif1.slave), .err_clr(err_clr),
      .FrameData(fd1), .FrameStrobe(fs1), .ColSelect(cs1),
      .done(dn1), .err(er1), .frame_count(fc1)
   );

   frame_strobe_ctrl #(.StrobeLen(15)) dut15 (
      .CLK(CLK), .reset(reset), .cfg(cif15.slave), .err_clr(err_clr),
      .FrameData(fd15), .FrameStrobe(fs15), .ColSelect(cs15),
      .done(dn15), .err(er15), .frame_count(fc15)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      total_cnt++;
      if (fs !== 20'h0 || cs !== 8'h0 || fd !== 32'h0)
         $display("FAIL reset_outs: fs=%h cs=%h fd=%h want 0", fs, cs, fd);
      else pass_cnt++;
      total_cnt++;
      if (dn !== 1'b0 || er !== 1'b0 || fc !== 16'h0)
         $display("FAIL reset_flags: done=%b err=%b cnt=%h want 0", dn, er, fc);
      else pass_cnt++;
      total_cnt++;
      if (cif.cfg_ready !== 1'b0)
         $display("FAIL reset_ready: got %b want 0", cif.cfg_ready);
      else pass_cnt++;
      reset = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      total_cnt++;
      if (cif.cfg_ready !== 1'b1 || cif1.cfg_ready !== 1'b1 || cif15.cfg_ready !== 1'b1)
         $display("FAIL ready_after_reset: got %b%b%b want 111",
                  cif.cfg_ready, cif1.cfg_ready, cif15.cfg_ready);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      logic [19:0] e_fs [1:5];
      logic [7:0]  e_cs [1:5];
      logic        e_dn [1:5];
      logic        e_rd [1:5];
      e_fs = '{20'h0, 20'h80, 20'h80, 20'h0, 20'h0};
      e_cs = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
      e_dn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      e_rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      cif.cfg_valid = 1'b1;
      cif.cfg_col   = 5'd3;
      cif.cfg_frame = 5'd7;
      cif.cfg_data  = 32'hDEADBEEF;
      @(posedge CLK);
      for (int k = 1; k <= 5; k++) begin
         @(negedge CLK);
         cif.cfg_valid = 1'b0;
         total_cnt++;
         if (fs !== e_fs[k])
            $display("FAIL basic_fs[%0d]: got %h want %h", k, fs, e_fs[k]);
         else pass_cnt++;
         total_cnt++;
         if (cs !== e_cs[k])
            $display("FAIL basic_cs[%0d]: got %h want %h", k, cs, e_cs[k]);
         else pass_cnt++;
         total_cnt++;
         if (dn !== e_dn[k])
            $display("FAIL basic_done[%0d]: got %b want %b", k, dn, e_dn[k]);
         else pass_cnt++;
         total_cnt++;
         if (cif.cfg_ready !== e_rd[k])
            $display("FAIL basic_ready[%0d]: got %b want %b", k, cif.cfg_ready, e_rd[k]);
         else pass_cnt++;
      end
      total_cnt++;
      if (fd !== 32'hDEADBEEF)
         $display("FAIL basic_data: got %h want deadbeef", fd);
      else pass_cnt++;
      total_cnt++;
      if (fc !== 16'd1)
         $display("FAIL basic_count: got %0d want 1", fc);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int a1 = -1;
      int a2 = -1;
      int ndone = 0;
      logic [19:0] seen [$];
      cif.cfg_valid = 1'b1;
      cif.cfg_col   = 5'd0;
      cif.cfg_frame = 5'd0;
      cif.cfg_data  = 32'h1111_0000;
      for (int i = 0; i < 20; i++) begin
         if (cif.cfg_ready && cif.cfg_valid) begin
            if (a1 < 0) a1 = i;
            else if (a2 < 0) a2 = i;
         end
         @(posedge CLK);
         @(negedge CLK);
         if (a1 >= 0 && a2 < 0) begin
            cif.cfg_col   = 5'd7;
            cif.cfg_frame = 5'd19;
            cif.cfg_data  = 32'h2222_0000;
         end
         if (a2 >= 0) cif.cfg_valid = 1'b0;
         if (dn) ndone++;
         if (fs != 20'h0 && (seen.size() == 0 || seen[$] != fs))
            seen.push_back(fs);
      end
      total_cnt++;
      if (a1 < 0 || a2 < 0 || a2 - a1 != 5)
         $display("FAIL b2b_gap: accepts at %0d,%0d want gap 5", a1, a2);
      else pass_cnt++;
      total_cnt++;
      if (seen.size() != 2)
         $display("FAIL b2b_nstrobe: got %0d want 2", seen.size());
      else if (seen[0] !== 20'h00001 || seen[1] !== 20'h80000)
         $display("FAIL b2b_strobe: got %h,%h want 00001,80000", seen[0], seen[1]);
      else pass_cnt++;
      total_cnt++;
      if (ndone != 2)
         $display("FAIL b2b_done: got %0d pulses want 2", ndone);
      else pass_cnt++;
      total_cnt++;
      if (fc !== 16'd3)
         $display("FAIL b2b_count: got %0d want 3", fc);
      else pass_cnt++;
   endtask

   task automatic test_err();
      int bad = 0;
      cif.cfg_valid = 1'b1;
      cif.cfg_col   = 5'd8;
      cif.cfg_frame = 5'd2;
      @(posedge CLK);
      @(negedge CLK);
      cif.cfg_valid = 1'b0;
      total_cnt++;
      if (er !== 1'b1)
         $display("FAIL err_set: got %b want 1", er);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         if (fs != 20'h0 || cs != 8'h0 || dn || !cif.cfg_ready) bad++;
         @(negedge CLK);
      end
      total_cnt++;
      if (bad != 0)
         $display("FAIL err_quiet: got %0d active cycles want 0", bad);
      else pass_cnt++;
      total_cnt++;
      if (fc !== 16'd3)
         $display("FAIL err_count: got %0d want 3", fc);
      else pass_cnt++;
      err_clr = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      err_clr = 1'b0;
      total_cnt++;
      if (er !== 1'b0)
         $display("FAIL err_clear: got %b want 0", er);
      else pass_cnt++;
      err_clr       = 1'b1;
      cif.cfg_valid = 1'b1;
      cif.cfg_col   = 5'd9;
      @(posedge CLK);
      @(negedge CLK);
      err_clr       = 1'b0;
      cif.cfg_valid = 1'b0;
      total_cnt++;
      if (er !== 1'b1)
         $display("FAIL err_set_wins: got %b want 1", er);
      else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int ndone = 0;
      cif.cfg_valid = 1'b1;
      cif.cfg_col   = 5'd2;
      cif.cfg_frame = 5'd4;
      cif.cfg_data  = 32'hA5A5_5A5A;
      @(posedge CLK);
      @(negedge CLK);
      cif.cfg_valid = 1'b0;
      @(negedge CLK);
      total_cnt++;
      if (fs !== 20'h10)
         $display("FAIL abort_pre_fs: got %h want 00010", fs);
      else pass_cnt++;
      reset = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      total_cnt++;
      if (fs !== 20'h0 || cs !== 8'h0)
         $display("FAIL abort_fs: fs=%h cs=%h want 0", fs, cs);
      else pass_cnt++;
      total_cnt++;
      if (cif.cfg_ready !== 1'b0)
         $display("FAIL abort_ready_rst: got %b want 0", cif.cfg_ready);
      else pass_cnt++;
      if (dn) ndone++;
      reset = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      total_cnt++;
      if (cif.cfg_ready !== 1'b1)
         $display("FAIL abort_ready: got %b want 1", cif.cfg_ready);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         if (dn || fs != 20'h0) ndone++;
         @(negedge CLK);
      end
      total_cnt++;
      if (ndone != 0)
         $display("FAIL abort_done: got %0d active cycles want 0", ndone);
      else pass_cnt++;
      total_cnt++;
      if (fc !== 16'd0)
         $display("FAIL abort_count: got %0d want 0", fc);
      else pass_cnt++;
   endtask

   task automatic test_strobe_len();
      int n1 = 0, n15 = 0, bad1 = 0, bad15 = 0, d1 = 0, d15 = 0;
      cif1.cfg_valid  = 1'b1;
      cif1.cfg_col    = 5'd1;
      cif1.cfg_frame  = 5'd5;
      cif1.cfg_data   = 32'h0000_0001;
      cif15.cfg_valid = 1'b1;
      cif15.cfg_col   = 5'd1;
      cif15.cfg_frame = 5'd5;
      cif15.cfg_data  = 32'h0000_000F;
      @(posedge CLK);
      @(negedge CLK);
      cif1.cfg_valid  = 1'b0;
      cif15.cfg_valid = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (fs1 != 20'h0) begin
            n1++;
            if (fs1 != 20'h20 || cs1 != 8'h02) bad1++;
         end
         if (fs15 != 20'h0) begin
            n15++;
            if (fs15 != 20'h20 || cs15 != 8'h02) bad15++;
         end
         if (dn1) d1++;
         if (dn15) d15++;
         @(negedge CLK);
      end
      total_cnt++;
      if (n1 != 1 || bad1 != 0)
         $display("FAIL len1: got %0d cycles (%0d bad) want 1", n1, bad1);
      else pass_cnt++;
      total_cnt++;
      if (n15 != 15 || bad15 != 0)
         $display("FAIL len15: got %0d cycles (%0d bad) want 15", n15, bad15);
      else pass_cnt++;
      total_cnt++;
      if (d1 != 1 || d15 != 1)
         $display("FAIL len_done: got %0d,%0d want 1,1", d1, d15);
      else pass_cnt++;
   endtask

   task automatic test_saturate();
      logic [15:0] e_fc [3];
      e_fc = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
      force dut.frame_count = 16'hFFFE;
      @(posedge CLK);
      @(negedge CLK);
      release dut.frame_count;
      @(negedge CLK);
      total_cnt++;
      if (fc !== 16'hFFFE)
         $display("FAIL sat_preload: got %h want fffe", fc);
      else pass_cnt++;
      for (int w = 0; w < 3; w++) begin
         cif.cfg_valid = 1'b1;
         cif.cfg_col   = 5'd4;
         cif.cfg_frame = 5'(w + 10);
         @(posedge CLK);
         @(negedge CLK);
         cif.cfg_valid = 1'b0;
         repeat (4) @(negedge CLK);
         total_cnt++;
         if (fc !== e_fc[w])
            $display("FAIL sat_count[%0d]: got %h want %h", w, fc, e_fc[w]);
         else pass_cnt++;
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      reset     = 1'b1;
      err_clr   = 1'b0;
      cif.cfg_valid   = 1'b0;
      cif.cfg_col     = '0;
      cif.cfg_frame   = '0;
      cif.cfg_data    = '0;
      cif1.cfg_valid  = 1'b0;
      cif1.cfg_col    = '0;
      cif1.cfg_frame  = '0;
      cif1.cfg_data   = '0;
      cif15.cfg_valid = 1'b0;
      cif15.cfg_col   = '0;
      cif15.cfg_frame = '0;
      cif15.cfg_data  = '0;
      @(negedge CLK);
      test_reset();
      test_basic();
      test_back_to_back();
      test_err();
      test_reset_abort();
      test_strobe_len();
      test_saturate();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
